// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives a hold-until-ok bus request, feeds decode through a 1-entry skid.
// Latency bus+1; stall holds f_*, parks one response in the skid. Define FETCH_MISALIGN_EN to trap misaligned redirects.
module fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter logic [31:0] INSTR_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_excp,
  output logic [63:0] last_pc
);

  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;

  state_t      state, state_nxt;
  logic        started;
  logic [63:0] pc;
  logic [63:0] pend_pc;
  logic        pend_bad;
  logic        skid_vld;
  logic [63:0] skid_pc;
  logic [31:0] skid_instr;

  logic [63:0] rpc;
  logic        rpc_bad;
  logic        consume;
  logic        resp_take;
  logic        redir_defer;
  logic        excp_load;
  logic [63:0] excp_pc;

`ifdef FETCH_MISALIGN_EN
  logic f_excp_q;
  assign rpc     = redirect_pc;
  assign rpc_bad = |redirect_pc[1:0];
  assign f_excp  = f_excp_q;
`else
  logic unused_rpc_lo;
  assign unused_rpc_lo = ^redirect_pc[1:0];
  assign rpc     = {redirect_pc[63:2], 2'b00};
  assign rpc_bad = 1'b0;
  assign f_excp  = 1'b0;
`endif

  assign consume   = f_valid & ~stall;
  assign resp_take = ireq_valid & iresp_ok;
  // A redirect against a request still in flight must wait for its ok before the bus address can change.
  assign redir_defer = redirect_valid & ~iresp_ok &
                       (((state == FETCH) & started) | (state == DRAIN));
  assign excp_load = redirect_valid ? (~redir_defer & rpc_bad)
                                    : ((state == DRAIN) & iresp_ok & pend_bad);
  assign excp_pc   = redirect_valid ? rpc : pend_pc;
  assign last_pc   = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      if (redir_defer)  state_nxt = DRAIN;
      else if (rpc_bad) state_nxt = HOLD;
      else              state_nxt = FETCH;
    end else begin
      case (state)
        FETCH:   if (resp_take && f_valid && stall) state_nxt = HOLD;
        HOLD:    if (consume && skid_vld) state_nxt = FETCH;
        DRAIN:   if (iresp_ok) state_nxt = pend_bad ? HOLD : FETCH;
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_comb begin
    ireq_valid = 1'b0;
    ireq_addr  = pc;
    case (state)
      FETCH:   ireq_valid = started;
      DRAIN:   ireq_valid = 1'b1;
      default: ireq_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started    <= 1'b0;
      pc         <= RESET_PC;
      pend_pc    <= '0;
      pend_bad   <= 1'b0;
      f_valid    <= 1'b0;
      f_pc       <= '0;
      f_instr    <= INSTR_NOP;
      skid_vld   <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= INSTR_NOP;
    end else begin
      started <= 1'b1;
      if (consume) f_valid <= 1'b0;
      if (redirect_valid) begin
        f_valid  <= 1'b0;
        skid_vld <= 1'b0;
        if (redir_defer) begin
          pend_pc  <= rpc;
          pend_bad <= rpc_bad;
        end else begin
          pc <= rpc;
        end
      end else begin
        case (state)
          FETCH: if (resp_take) begin
            pc <= pc + 64'd4;
            if (!f_valid || consume) begin
              f_valid <= 1'b1;
              f_pc    <= pc;
              f_instr <= iresp_data;
            end else begin
              skid_vld   <= 1'b1;
              skid_pc    <= pc;
              skid_instr <= iresp_data;
            end
          end
          HOLD: if (consume && skid_vld) begin
            f_valid  <= 1'b1;
            f_pc     <= skid_pc;
            f_instr  <= skid_instr;
            skid_vld <= 1'b0;
          end
          DRAIN: if (iresp_ok) pc <= pend_pc;
          default: ;
        endcase
      end
      // A trapped redirect parks in HOLD with an empty skid, so it stays there until the next redirect.
      if (excp_load) begin
        f_valid <= 1'b1;
        f_pc    <= excp_pc;
        f_instr <= INSTR_NOP;
      end
    end
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f_excp_q <= 1'b0;
    end else begin
      if (consume || redirect_valid) f_excp_q <= 1'b0;
      if (excp_load)                 f_excp_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: bus responses are driven by hand each cycle, outputs checked on the falling edge.
module tb_fetch_unit;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        f_valid;
  logic [63:0] f_pc;
  logic [31:0] f_instr;
  logic        f_excp;
  logic [63:0] last_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_ok(iresp_ok), .iresp_data(iresp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_excp(f_excp),
    .last_pc(last_pc)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ok, input logic [31:0] d, input logic st,
                       input logic rv, input logic [63:0] rp);
    iresp_ok       = ok;
    iresp_data     = d;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step; step;
    check("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    check("rst_f_valid",    {63'd0, f_valid}, 64'd0);
    check("rst_f_pc",       f_pc, 64'd0);
    check("rst_f_instr",    {32'd0, f_instr}, {32'd0, NOP});
    check("rst_f_excp",     {63'd0, f_excp}, 64'd0);
    check("rst_last_pc",    last_pc, RST_PC);

    reset = 1'b1;
    check("first_cyc_no_req", {63'd0, ireq_valid}, 64'd0);
    step;
    check("zw_req0_vld",  {63'd0, ireq_valid}, 64'd1);
    check("zw_req0_addr", ireq_addr, 64'h8000_0000);
    drive(1'b1, 32'h1111_0013, 1'b0, 1'b0, 64'h0);
    step;
    check("zw_f0_vld",    {63'd0, f_valid}, 64'd1);
    check("zw_f0_pc",     f_pc, 64'h8000_0000);
    check("zw_f0_instr",  {32'd0, f_instr}, 64'h1111_0013);
    check("zw_req1_addr", ireq_addr, 64'h8000_0004);
    check("zw_last_pc",   last_pc, 64'h8000_0004);
    drive(1'b1, 32'h2222_0013, 1'b0, 1'b0, 64'h0);
    step;
    check("zw_f1_pc",     f_pc, 64'h8000_0004);
    check("zw_f1_instr",  {32'd0, f_instr}, 64'h2222_0013);
    check("zw_req2_addr", ireq_addr, 64'h8000_0008);

    // stall for three edges while a response lands in the skid
    drive(1'b1, 32'h3333_0013, 1'b1, 1'b0, 64'h0);
    step;
    check("hold_no_req",   {63'd0, ireq_valid}, 64'd0);
    check("hold_f_pc",     f_pc, 64'h8000_0004);
    check("hold_f_instr",  {32'd0, f_instr}, 64'h2222_0013);
    check("hold_f_vld",    {63'd0, f_valid}, 64'd1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
    step;
    check("hold2_no_req",  {63'd0, ireq_valid}, 64'd0);
    check("hold2_f_instr", {32'd0, f_instr}, 64'h2222_0013);
    step;
    check("hold3_f_pc",    f_pc, 64'h8000_0004);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step;
    check("skid_f_pc",     f_pc, 64'h8000_0008);
    check("skid_f_instr",  {32'd0, f_instr}, 64'h3333_0013);
    check("skid_req_vld",  {63'd0, ireq_valid}, 64'd1);
    check("skid_req_addr", ireq_addr, 64'h8000_000C);

    // redirect against an outstanding request: address must hold until ok
    drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_0100);
    step;
    check("drain_no_dup",   {63'd0, f_valid}, 64'd0);
    check("drain_req_vld",  {63'd0, ireq_valid}, 64'd1);
    check("drain_addr",     ireq_addr, 64'h8000_000C);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step;
    check("drain2_addr",    ireq_addr, 64'h8000_000C);
    check("drain2_f_vld",   {63'd0, f_valid}, 64'd0);
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 64'h0);
    step;
    check("drain_done_addr", ireq_addr, 64'h8000_0100);
    check("drain_discard",   {63'd0, f_valid}, 64'd0);
    check("drain_done_vld",  {63'd0, ireq_valid}, 64'd1);

    drive(1'b1, 32'h4444_0013, 1'b0, 1'b0, 64'h0);
    step;
    check("tgt_f_pc",    f_pc, 64'h8000_0100);
    check("tgt_f_instr", {32'd0, f_instr}, 64'h4444_0013);
    check("tgt_f_vld",   {63'd0, f_valid}, 64'd1);

    // redirect + ok + stall in the same cycle: response dropped, output flushed
    drive(1'b1, 32'h5555_0013, 1'b1, 1'b1, 64'h8000_0200);
    step;
    check("same_flush",  {63'd0, f_valid}, 64'd0);
    check("same_addr",   ireq_addr, 64'h8000_0200);
    check("same_req",    {63'd0, ireq_valid}, 64'd1);
    drive(1'b1, 32'h6666_0013, 1'b0, 1'b0, 64'h0);
    step;
    check("same_f_pc",    f_pc, 64'h8000_0200);
    check("same_f_instr", {32'd0, f_instr}, 64'h6666_0013);
    check("same_next",    ireq_addr, 64'h8000_0204);

    // enter DRAIN, then reset asynchronously
    drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h8000_0300);
    step;
    check("pre_rst_req",  {63'd0, ireq_valid}, 64'd1);
    check("pre_rst_addr", ireq_addr, 64'h8000_0204);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    reset = 1'b0;
    #1;
    check("arst_no_req",  {63'd0, ireq_valid}, 64'd0);
    check("arst_last_pc", last_pc, RST_PC);
    step;
    reset = 1'b1;
    drive(1'b1, 32'hBAD0_0013, 1'b0, 1'b0, 64'h0);
    step;
    check("late_ok_f_vld", {63'd0, f_valid}, 64'd0);
    check("late_ok_pc",    last_pc, RST_PC);
    check("late_ok_req",   {63'd0, ireq_valid}, 64'd1);

    // misaligned redirect taken together with an ok (not deferred)
    drive(1'b1, 32'h7777_0013, 1'b0, 1'b1, 64'h8000_0102);
    step;
`ifdef FETCH_MISALIGN_EN
    check("mis_f_vld",   {63'd0, f_valid}, 64'd1);
    check("mis_f_pc",    f_pc, 64'h8000_0102);
    check("mis_f_instr", {32'd0, f_instr}, {32'd0, NOP});
    check("mis_f_excp",  {63'd0, f_excp}, 64'd1);
    check("mis_no_req",  {63'd0, ireq_valid}, 64'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step;
    check("mis_park_req", {63'd0, ireq_valid}, 64'd0);
    check("mis_park_vld", {63'd0, f_valid}, 64'd0);
`else
    check("mis_f_vld",   {63'd0, f_valid}, 64'd0);
    check("mis_f_excp",  {63'd0, f_excp}, 64'd0);
    check("mis_req",     {63'd0, ireq_valid}, 64'd1);
    check("mis_addr",    ireq_addr, 64'h8000_0100);
    check("mis_last_pc", last_pc, 64'h8000_0100);
    drive(1'b1, 32'h8888_0013, 1'b0, 1'b0, 64'h0);
    step;
    check("mis_f_pc",    f_pc, 64'h8000_0100);
    check("mis_f_instr", {32'd0, f_instr}, 64'h8888_0013);
    check("mis_excp2",   {63'd0, f_excp}, 64'd0);
`endif

    // pc+4 wraps modulo 2^64
    drive(1'b1, 32'h9999_0013, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step;
    check("wrap_addr0", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b1, 32'hAAAA_0013, 1'b0, 1'b0, 64'h0);
    step;
    check("wrap_addr1",   ireq_addr, 64'h0);
    check("wrap_f_pc",    f_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_f_instr", {32'd0, f_instr}, 64'hAAAA_0013);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
    step;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of decode.
- Owns the architectural PC and drives the instruction bus with a hold-until-ok request handshake.
- Presents {pc, instr, valid} to the decode latch and accepts decode's redirect (PCSel / pc_address).
- Exports the PC currently being fetched (last_pc), so decode can skip redirects whose target is already in flight.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
- INSTR_NOP, 32'h0000_0013, instruction word driven when no valid fetch is presented.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserted (0) clears state immediately; deassertion is synchronous to clk.
- ireq_valid  out  1  instruction bus request.
- ireq_addr  out  64  fetch address; stable while ireq_valid=1 and iresp_ok=0.
- iresp_ok  in  1  one-cycle pulse; request completed; iresp_data valid this cycle.
- iresp_data  in  32  fetched instruction word.
- redirect_valid  in  1  decode's PCSel.
- redirect_pc  in  64  decode's pc_address.
- stall  in  1  decode cannot accept this cycle.
- f_valid  out  1  fetch output valid.
- f_pc  out  64  PC of f_instr.
- f_instr  out  32  instruction word.
- f_excp  out  1  instruction-address-misaligned flag (see Optional Feature).
- last_pc  out  64  PC currently being fetched (= pc register).

Behaviour:
- Reset values:
  - pc=RESET_PC, state=FETCH, ireq_valid=0 during reset.
  - f_valid=0, f_pc=0, f_instr=INSTR_NOP, f_excp=0, skid empty.
  - Reset mid-transaction abandons the request; a late iresp_ok after reset release while in FETCH with no issued request is ignored.
- Registers: pc; output register (f_*); one-entry skid {pc, instr}; pend_pc; state ∈ {FETCH, HOLD, DRAIN}.
- Output consume: the output register is consumed when f_valid=1 and stall=0.
- FETCH:
  - ireq_valid=1 and ireq_addr=pc, except in the first cycle after reset release, when ireq_valid=0.
  - On iresp_ok with the output free (f_valid=0) or being consumed: load f_* from {pc, iresp_data}, set pc=pc+4, stay in FETCH.
  - On iresp_ok with the output blocked: write the skid, set pc=pc+4, go to HOLD.
- HOLD:
  - ireq_valid=0.
  - When the output is consumed: move skid → output, clear skid, go to FETCH.
- DRAIN:
  - ireq_valid=1 with the old address held stable.
  - On iresp_ok: discard the data, set pc=pend_pc, go to FETCH.
  - A further redirect while in DRAIN overwrites pend_pc.
- Redirect (redirect_valid=1):
  - Has priority over stall and over any same-cycle iresp_ok data.
  - Next cycle: f_valid=0 and skid cleared (wrong-path flush).
  - If in FETCH with ireq_valid=1 and iresp_ok=0: pend_pc=redirect_pc, go to DRAIN.
  - Otherwise (iresp_ok this cycle, or HOLD, or no request issued): pc=redirect_pc, go to FETCH, and the same-cycle response is dropped.
- Latency and throughput:
  - Fetch latency is bus latency + 1: f_valid rises the cycle after iresp_ok.
  - With a zero-wait bus and no stall, throughput is one instruction per cycle.
- Arithmetic:
  - pc+4 is 64-bit and wraps modulo 2^64 with no trap.
  - redirect_pc alignment is handled per the Optional Feature.
- Stall with no redirect: f_* held unchanged.

Optional Feature:
- Macro: FETCH_MISALIGN_EN.
- When defined:
  - A redirect_pc with bits [1:0] ≠ 0 issues no bus request.
  - The next cycle (after any DRAIN completes) presents f_valid=1, f_pc=redirect_pc, f_instr=INSTR_NOP, f_excp=1.
  - The block then holds in HOLD with ireq_valid=0 until another redirect arrives.
- When undefined:
  - redirect_pc[1:0] is forced to 2'b00 before use.
  - f_excp is tied to 0.

Test Plan:
- Reset release, zero-wait bus returning 32'h0000_0013, stall=0 → ireq_addr 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles; f_pc follows one cycle later; last_pc=0x8000_0004 while the second fetch is outstanding.
- stall=1 for 3 cycles with a response arriving → skid captures the instruction, ireq_valid=0 in HOLD, f_* stable; after stall drops, two instructions emerge in order with no loss or duplication.
- redirect_valid=1, redirect_pc=0x8000_0100 while a 3-cycle-latency request to 0x8000_0008 is outstanding → ireq_addr stays 0x8000_0008 until ok, data discarded, next request is 0x8000_0100, f_valid=0 throughout.
- Redirect in the same cycle as iresp_ok and stall=1 → response dropped, f_valid=0 next cycle, next ireq_addr = redirect target.
- Assert reset (0) mid-DRAIN → ireq_valid=0 immediately; after release, pc=RESET_PC and the late iresp_ok is ignored.
- Redirect to 0x8000_0102:
  - FETCH_MISALIGN_EN defined: f_excp=1, f_pc=0x8000_0102, no bus request.
  - FETCH_MISALIGN_EN undefined: fetch from 0x8000_0100, f_excp=0.
